// File: rtl/nn_output_reader.sv
// nn_output_reader: read-out engine for the 4-neuron network.
// It steps selector_output through every neuron index and waits a settle
// window at each one. It then captures network_outputs and streams the byte
// to the host over a valid/ready interface.
// Optional feature macro: NN_READ_CHECKSUM_EN appends an XOR checksum byte
// to every frame.
module nn_output_reader #(
    parameter int NUM_NEURONS   = 4,
    parameter int SEL_W         = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       network_outputs,
    input  logic             tx_ready,
    output logic [SEL_W-1:0] selector_output,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             busy,
    output logic             done
);

`ifdef NN_READ_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE,
        SEL,
        WAIT,
        SEND,
        CHK,
        DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        SEL,
        WAIT,
        SEND,
        DONE
    } state_t;
`endif

    localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_NEURONS - 1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] idx_next;
    logic [3:0]       cnt;
    logic [3:0]       cnt_next;
    logic [SEL_W-1:0] sel_next;
    logic [7:0]       data_next;
    logic             valid_next;
    logic             busy_next;
    logic             done_next;
`ifdef NN_READ_CHECKSUM_EN
    logic [7:0]       chk;
    logic [7:0]       chk_next;
`endif

    // State and all registered outputs; reset wins over everything and drops any in-flight byte
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            cnt             <= '0;
            selector_output <= '0;
            tx_data         <= 8'h00;
            tx_valid        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
`ifdef NN_READ_CHECKSUM_EN
            chk             <= 8'h00;
`endif
        end else begin
            state           <= state_next;
            idx             <= idx_next;
            cnt             <= cnt_next;
            selector_output <= sel_next;
            tx_data         <= data_next;
            tx_valid        <= valid_next;
            busy            <= busy_next;
            done            <= done_next;
`ifdef NN_READ_CHECKSUM_EN
            chk             <= chk_next;
`endif
        end
    end

    // Next-state and next-output decisions; everything holds unless a state says otherwise
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        sel_next   = selector_output;
        data_next  = tx_data;
        valid_next = tx_valid;
        busy_next  = busy;
        done_next  = 1'b0;
`ifdef NN_READ_CHECKSUM_EN
        chk_next   = chk;
`endif
        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    idx_next   = '0;
                    busy_next  = 1'b1;
                    state_next = SEL;
`ifdef NN_READ_CHECKSUM_EN
                    chk_next   = 8'h00;
`endif
                end
            end
            SEL: begin
                sel_next   = idx;
                cnt_next   = SETTLE_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    data_next  = network_outputs;
                    valid_next = 1'b1;
                    state_next = SEND;
`ifdef NN_READ_CHECKSUM_EN
                    chk_next   = chk ^ network_outputs;
`endif
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (idx == LAST_IDX) begin
`ifdef NN_READ_CHECKSUM_EN
                        data_next  = chk;
                        state_next = CHK;
`else
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
`endif
                    end else begin
                        valid_next = 1'b0;
                        idx_next   = idx + SEL_W'(1);
                        state_next = SEL;
                    end
                end
            end
`ifdef NN_READ_CHECKSUM_EN
            CHK: begin
                if (tx_valid && tx_ready) begin
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nn_output_reader.sv
// tb_nn_output_reader: scoreboard bench for nn_output_reader.
// Each frame pushes its expected byte sequence into a queue. A monitor pops
// and compares on every host handshake. Frame timing follows from
// NUM_NEURONS*(SETTLE+3) plus checksum and stall cycles.
module tb_nn_output_reader;

    localparam int NUM_NEURONS = 4;
    localparam int SETTLE      = 2;
`ifdef NN_READ_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif
    localparam int FRAME_EDGES = NUM_NEURONS * (SETTLE + 3) + CHK_BYTES;
    localparam int FRAME_BYTES = NUM_NEURONS + CHK_BYTES;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       tx_ready;
    logic [7:0] network_outputs;
    logic [1:0] selector_output;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       done;

    logic [7:0] model_tab [4];
    bit         slow_mode = 1'b0;
    int         age = 15;
    logic [1:0] last_sel = 2'd0;

    logic [7:0] exp_q [$];
    logic [7:0] exp_byte;
    int         n_checks = 0;
    int         n_fails = 0;
    int         bytes_seen = 0;
    int         done_count = 0;
    int         edges;
    int         dc;
    int         n;

    nn_output_reader #(
        .NUM_NEURONS  (NUM_NEURONS),
        .SEL_W        (2),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .network_outputs(network_outputs),
        .tx_ready       (tx_ready),
        .selector_output(selector_output),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Network model: output from the table; in slow mode 0xFF until 2 cycles after a selector change
    assign network_outputs = (slow_mode && age < 2) ? 8'hFF : model_tab[selector_output];

    // Track how many cycles the selector has been stable
    always @(negedge clk) begin
        if (selector_output != last_sel) begin
            last_sel = selector_output;
            age = 0;
        end else if (age < 15) begin
            age++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops the scoreboard; done pulses are counted
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                exp_byte = exp_q.pop_front();
                checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_byte});
            end
            bytes_seen++;
        end
        if (!reset && done) begin
            done_count++;
        end
    end

    // Fill the table (optionally random) and push the frame's expected bytes
    task automatic loadFrame(input bit randomData);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (randomData) model_tab[i] = 8'($urandom_range(0, 254));
            exp_q.push_back(model_tab[i]);
            x ^= model_tab[i];
        end
`ifdef NN_READ_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic waitSel(input int idx);
        int w;
        w = 0;
        @(negedge clk);
        while (selector_output != 2'(idx) && w < 200) begin
            @(negedge clk);
            w++;
        end
        checkOutput("sel_wait_timeout", {31'd0, w < 200}, 32'd1);
    endtask

    task automatic waitValid();
        int w;
        w = 0;
        @(negedge clk);
        while (!tx_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        checkOutput("valid_wait_timeout", {31'd0, w < 200}, 32'd1);
    endtask

    // One frame: start pulse, optional stall on one byte or a stray start, timing checks
    task automatic applyStimulus(input int stallIdx, input int stallCycles, input bit repulse,
                                 input bit keepStart);
        int cnt;
        bytes_seen = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 if (!keepStart) start = 1'b0;
        fork
            begin
                cnt = 0;
                while (cnt < 400) begin
                    @(posedge clk);
                    cnt++;
                    @(negedge clk);
                    if (done) break;
                end
            end
            begin
                if (repulse) begin
                    repeat (7) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                end
                if (stallIdx >= 0) begin
                    waitSel(stallIdx);
                    @(posedge clk);
                    #1 tx_ready = 1'b0;
                    waitValid();
                    for (int i = 0; i < stallCycles; i++) begin
                        if (i > 0) @(negedge clk);
                        checkOutput("stall_data", {24'd0, tx_data}, {24'd0, model_tab[stallIdx]});
                        checkOutput("stall_sel", {30'd0, selector_output}, 32'(stallIdx));
                        checkOutput("stall_valid", {31'd0, tx_valid}, 32'd1);
                    end
                    @(posedge clk);
                    #1 tx_ready = 1'b1;
                end
            end
        join
        checkOutput("done_edges", 32'(cnt), 32'(FRAME_EDGES + stallCycles));
        checkOutput("busy_during_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("busy_after", {31'd0, busy}, 32'd0);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("byte_count", 32'(bytes_seen), 32'(FRAME_BYTES));
    endtask

    // Main sequence
    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b1;
        model_tab[0] = 8'h11;
        model_tab[1] = 8'h22;
        model_tab[2] = 8'h33;
        model_tab[3] = 8'h44;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_sel", {30'd0, selector_output}, 32'd0);
        checkOutput("reset_data", {24'd0, tx_data}, 32'd0);

        $display("[TB] basic frame 11/22/33/44");
        loadFrame(1'b0);
        applyStimulus(-1, 0, 1'b0, 1'b0);

        $display("[TB] slow network, settle window");
        slow_mode = 1'b1;
        loadFrame(1'b1);
        applyStimulus(-1, 0, 1'b0, 1'b0);
        slow_mode = 1'b0;

        $display("[TB] tx_ready low for 7 cycles on byte 2");
        loadFrame(1'b1);
        applyStimulus(2, 7, 1'b0, 1'b0);

        $display("[TB] reset while byte 1 is pending");
        loadFrame(1'b1);
        bytes_seen = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitSel(1);
        @(posedge clk);
        #1 tx_ready = 1'b0;
        waitValid();
        checkOutput("pre_reset_bytes", 32'(bytes_seen), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        tx_ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("mid_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_reset_sel", {30'd0, selector_output}, 32'd0);
        loadFrame(1'b1);
        applyStimulus(-1, 0, 1'b0, 1'b0);

        $display("[TB] stray start during a frame");
        dc = done_count;
        loadFrame(1'b1);
        applyStimulus(-1, 0, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        checkOutput("single_done", 32'(done_count), 32'(dc + 1));
        checkOutput("no_rearm_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("no_rearm_busy", {31'd0, busy}, 32'd0);

        $display("[TB] start held high re-arms after done");
        loadFrame(1'b1);
        applyStimulus(-1, 0, 1'b0, 1'b1);
        loadFrame(1'b0);
        bytes_seen = 0;
        @(negedge clk);
        checkOutput("rearm_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
        end
        checkOutput("rearm_done_edges", 32'(n), 32'(FRAME_EDGES));
        @(negedge clk);
        checkOutput("rearm_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("rearm_byte_count", 32'(bytes_seen), 32'(FRAME_BYTES));

        $display("[TB] random frames");
        for (int f = 0; f < 4; f++) begin
            loadFrame(1'b1);
            if (f[0]) applyStimulus(int'($urandom_range(1, 2)), int'($urandom_range(1, 5)), 1'b0, 1'b0);
            else applyStimulus(-1, 0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time bound so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time bound, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
